puf_eval_ctrl: RTL and testbench
================================

# puf_eval_ctrl

Challenge sequencer and response evaluator that sits directly upstream and downstream of the 64-stage, 4-line OIPUF core. It accepts a challenge over a valid/ready handshake and drives the core's challenge and trigger inputs. It fires NVOTE timed trigger pulses and samples the core's raw arbiter outputs and per-arbiter stability flags through synchronizers. It returns a majority-voted TW-bit response, its XOR, and per-bit instability flags over a second valid/ready handshake.

## Interface
- TW, 4: number of arbiter outputs from the core.
- ST, 64: challenge width.
- NVOTE, 7: evaluations per challenge; odd, ≥1.
- SETTLE_CYC, 8: cycles puf_trig is held high before sampling; ≥3.
- REST_CYC, 4: cycles puf_trig is held low after each sample; ≥1.
- clk  in  1  system clock; all logic in this single domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- chal_in  in  ST  challenge from host.
- chal_valid  in  1  chal_in valid.
- chal_ready  out  1  block can accept a challenge.
- puf_chal  out  ST  challenge to core.
- puf_trig  out  1  trigger to core.
- puf_resp  in  TW  raw arbiter outputs; asynchronous to clk.
- puf_stable_each  in  TW  raw per-arbiter stability; asynchronous to clk.
- out_resp  out  TW  voted response.
- out_resp_xor  out  1  XOR of out_resp.
- out_unstable  out  TW  per-bit instability flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE, LAUNCH, REST, DONE.
- IDLE:
  - chal_ready=1.
  - On chal_valid&&chal_ready: register chal_in into puf_chal, clear the accumulators and vote index, then go to LAUNCH.
- LAUNCH:
  - puf_trig=1 for exactly SETTLE_CYC cycles.
  - In the last cycle, sample the synchronized puf_resp and puf_stable_each.
  - Go to REST.
- REST:
  - puf_trig=0 for REST_CYC cycles.
  - At the end, if vote index = NVOTE-1 go to DONE; otherwise increment the vote index and go to LAUNCH.
- DONE:
  - out_valid=1 and outputs held stable until out_valid&&out_ready, then go to IDLE.
  - chal_ready=0.
- puf_chal is held constant from capture until the DONE handshake completes.
- Accumulation, per bit i:
  - ones[i] += sampled resp[i]. Width of ones[i] is $clog2(NVOTE+1) and it cannot overflow.
  - bad[i] is set if any sampled stable_each[i]==0.
- Result, per bit i:
  - out_resp[i] = (ones[i] > NVOTE/2).
  - out_unstable[i] = bad[i] OR (ones[i]≠0 AND ones[i]≠NVOTE).
  - out_resp_xor = ^out_resp.
- out_resp, out_resp_xor and out_unstable are registered and change only on the transition into DONE.
- Asynchronous reset, including mid-evaluation:
  - Immediately force IDLE, puf_trig=0, and discard accumulators.
  - No partial result is ever emitted.
  - Synchronizer flops reset to 0.
- Reset values:
  - chal_ready=1, out_valid=0, puf_trig=0.
  - puf_chal=0, out_resp=0, out_resp_xor=0, out_unstable=0.
- chal_valid is ignored outside IDLE. out_ready is ignored outside DONE.

## Timing
- Handshake on cycle e0 puts puf_trig high from cycle e0+1.
- Each evaluation lasts SETTLE_CYC+REST_CYC cycles.
- out_valid rises at cycle e0 + NVOTE·(SETTLE_CYC+REST_CYC) + 1. With defaults this is e0+85.
- The synchronizer is two flops, so sampled data reflects the core 2–3 cycles earlier. SETTLE_CYC ≥ 3 guarantees the sample follows the rising trigger edge.
- Back-to-back operation:
  - The DONE handshake at cycle d puts the block in IDLE at d+1.
  - A new challenge can be accepted at d+1 at the earliest.
  - Minimum interval between challenges is NVOTE·(S+R)+2 cycles.
- No combinational path from any input to any output, except chal_ready and out_valid, which are decoded directly from state flops.

## Configuration
- PUF_EVAL_VOTE_EN defined: majority over NVOTE evaluations as specified above.
- PUF_EVAL_VOTE_EN undefined:
  - NVOTE is treated as 1 and the vote counters are not built.
  - out_resp is the single sample.
  - out_unstable[i] = bad[i] only.
  - out_valid rises at e0+S+R+1.

## Structure
- Package puf_eval_pkg holds:
  - the state enum (IDLE, LAUNCH, REST, DONE);
  - localparam helpers for counter widths: $clog2(SETTLE_CYC), $clog2(REST_CYC), $clog2(NVOTE+1), $clog2(NVOTE).
- Sub-module puf_sync2: parameterized-width two-flop synchronizer with async active-low reset. It is instantiated once, at width 2·TW, covering puf_resp and puf_stable_each.
- The timing counter, vote counters and FSM all live in puf_eval_ctrl.

## Test plan
- Reset mid-evaluation: hold puf_resp=4'b1111, accept a challenge, then assert rst_n=0 in the 3rd LAUNCH cycle -> puf_trig=0 and chal_ready=1 immediately, out_valid never rises, and the next challenge yields a full 85-cycle evaluation.
- Clean evaluation: accept chal_in=64'hDEADBEEF_01234567 with puf_resp=4'b1010 and puf_stable_each=4'b1111 constant -> puf_chal equals that challenge throughout, out_valid at e0+85, out_resp=4'b1010, out_resp_xor=0, out_unstable=4'b0000.
- Noisy bit: bit 0 is 1 in evaluations 0–3 and 0 in evaluations 4–6, other bits 0 -> out_resp=4'b0001, out_unstable=4'b0001.
- Stability flag: all resp bits 1 and puf_stable_each[3]=0 during evaluation 5 only -> out_resp=4'b1111, out_resp_xor=0, out_unstable=4'b1000.
- Back-pressure and overlap: hold out_ready=0 for 20 cycles in DONE while chal_valid=1 -> outputs frozen, chal_ready=0, second challenge accepted only the cycle after the out_ready handshake.
- Macro undefined: same stimulus as the noisy-bit scenario -> out_valid at e0+13, out_resp=4'b0001, out_unstable=4'b0000.

Source files
------------

// File: rtl/puf_eval_pkg.sv
// puf_eval_pkg
// Shared definitions for the PUF challenge sequencer / response evaluator.
//   - state_t : evaluation FSM state encoding (IDLE, LAUNCH, REST, DONE)
//   - cnt_w   : counter width helper, $clog2(n) floored at one bit so that a
//               count range of a single value still gets a real register
//   - the named width helpers below apply cnt_w to the quantities the
//     controller counts: settle cycles, rest cycles, vote tallies, vote index
// Optional feature macro (used by puf_eval_ctrl): PUF_EVAL_VOTE_EN
package puf_eval_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    REST   = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the counter timing the trigger-high phase: $clog2(SETTLE_CYC).
  function automatic int settle_w(input int settle_cyc);
    return cnt_w(settle_cyc);
  endfunction

  // Width of the counter timing the trigger-low phase: $clog2(REST_CYC).
  function automatic int rest_w(input int rest_cyc);
    return cnt_w(rest_cyc);
  endfunction

  // Width of a per-bit ones tally, which must hold 0..NVOTE: $clog2(NVOTE+1).
  function automatic int ones_w(input int nvote);
    return cnt_w(nvote + 1);
  endfunction

  // Width of the vote index, which holds 0..NVOTE-1: $clog2(NVOTE).
  function automatic int vidx_w(input int nvote);
    return cnt_w(nvote);
  endfunction

endpackage

// File: rtl/puf_sync2.sv
// puf_sync2
// Two-flop synchronizer for a bus of independent asynchronous bits. Each bit
// is synchronized on its own; no cross-bit coherency is implied.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both stages clear to 0
//   d     : asynchronous input bus (W bits)
//   q     : synchronized output bus (W bits), two cycles of latency
module puf_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture pipeline; first stage may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl
// Challenge sequencer and response evaluator for a 4-line OIPUF core.
// Accepts a challenge, fires NVOTE timed trigger pulses at the core, samples
// the synchronized arbiter outputs and stability flags once per pulse, and
// returns a majority-voted response with per-bit instability flags.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   chal_in/valid/ready : challenge input handshake
//   puf_chal, puf_trig  : challenge and trigger driven to the core
//   puf_resp, puf_stable_each : raw (asynchronous) core outputs
//   out_resp, out_resp_xor, out_unstable, out_valid/ready : result handshake
// Macro PUF_EVAL_VOTE_EN: when defined, majority over NVOTE evaluations;
// when undefined, a single evaluation per challenge with no vote counters.
module puf_eval_ctrl
  import puf_eval_pkg::*;
#(
  parameter int TW         = 4,
  parameter int ST         = 64,
  parameter int NVOTE      = 7,
  parameter int SETTLE_CYC = 8,
  parameter int REST_CYC   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [ST-1:0] chal_in,
  input  logic          chal_valid,
  output logic          chal_ready,
  output logic [ST-1:0] puf_chal,
  output logic          puf_trig,
  input  logic [TW-1:0] puf_resp,
  input  logic [TW-1:0] puf_stable_each,
  output logic [TW-1:0] out_resp,
  output logic          out_resp_xor,
  output logic [TW-1:0] out_unstable,
  output logic          out_valid,
  input  logic          out_ready
);

  // One shared timer serves both phases, so it is sized for the longer one.
  localparam int SETTLE_W = settle_w(SETTLE_CYC);
  localparam int REST_W   = rest_w(REST_CYC);
  localparam int TMR_W    = (SETTLE_W > REST_W) ? SETTLE_W : REST_W;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] REST_LAST   = TMR_W'(REST_CYC - 1);

  // Reject configurations the timing scheme cannot honour: an even vote
  // count has no majority, and fewer than three settle cycles would let the
  // sample see data from before the trigger edge through the synchronizer.
  if ((NVOTE < 1) || ((NVOTE % 2) == 0) || (SETTLE_CYC < 3) || (REST_CYC < 1)) begin : g_bad_cfg
    $error("puf_eval_ctrl: illegal NVOTE/SETTLE_CYC/REST_CYC configuration");
  end

  state_t           state;
  state_t           next_state;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_next;
  logic             accept;
  logic             sample;
  logic             finish;
  logic             vote_last;
  logic [2*TW-1:0]  sync_q;
  logic [TW-1:0]    samp_resp;
  logic [TW-1:0]    samp_stab;
  logic [TW-1:0]    bad;
  logic [TW-1:0]    res_resp;
  logic [TW-1:0]    res_unstable;

  puf_sync2 #(
    .W (2*TW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({puf_stable_each, puf_resp}),
    .q     (sync_q)
  );

  assign samp_resp = sync_q[TW-1:0];
  assign samp_stab = sync_q[2*TW-1:TW];

`ifdef PUF_EVAL_VOTE_EN
  localparam int ONES_W = ones_w(NVOTE);
  localparam int VIDX_W = vidx_w(NVOTE);

  logic [TW-1:0][ONES_W-1:0] ones;
  logic [VIDX_W-1:0]         vidx;

  assign vote_last = (vidx == VIDX_W'(NVOTE - 1));

  // Vote index and per-bit ones tallies; cleared at challenge capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vidx <= '0;
      ones <= '0;
    end else if (accept) begin
      vidx <= '0;
      ones <= '0;
    end else begin
      if (sample) begin
        for (int i = 0; i < TW; i++) begin
          ones[i] <= ones[i] + ONES_W'(samp_resp[i]);
        end
      end
      if ((state == REST) && (tmr == REST_LAST) && !vote_last) begin
        vidx <= vidx + VIDX_W'(1);
      end
    end
  end

  // Majority decision and instability per bit from the tallies.
  always_comb begin
    res_resp     = '0;
    res_unstable = '0;
    for (int i = 0; i < TW; i++) begin
      res_resp[i]     = (ones[i] > ONES_W'(NVOTE / 2));
      res_unstable[i] = bad[i] | ((ones[i] != ONES_W'(0)) && (ones[i] != ONES_W'(NVOTE)));
    end
  end
`else
  logic [TW-1:0] single;

  assign vote_last = 1'b1;

  // The one sample per challenge is kept as-is; cleared at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      single <= '0;
    end else if (accept) begin
      single <= '0;
    end else if (sample) begin
      single <= samp_resp;
    end
  end

  // Without voting the response is the sample and only the flags matter.
  always_comb begin
    res_resp     = single;
    res_unstable = bad;
  end
`endif

  // Next-state, phase timer and event decode.
  always_comb begin
    next_state = state;
    tmr_next   = tmr;
    accept     = 1'b0;
    sample     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (chal_valid && chal_ready) begin
          accept     = 1'b1;
          next_state = LAUNCH;
          tmr_next   = '0;
        end else begin
          next_state = IDLE;
        end
      end
      LAUNCH: begin
        if (tmr == SETTLE_LAST) begin
          sample     = 1'b1;
          next_state = REST;
          tmr_next   = '0;
        end else begin
          tmr_next = tmr + TMR_W'(1);
        end
      end
      REST: begin
        if (tmr == REST_LAST) begin
          tmr_next = '0;
          if (vote_last) begin
            finish     = 1'b1;
            next_state = DONE;
          end else begin
            next_state = LAUNCH;
          end
        end else begin
          tmr_next = tmr + TMR_W'(1);
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state = IDLE;
        tmr_next   = '0;
      end
    endcase
  end

  // State, timer and the state-decoded control outputs. The outputs are
  // loaded from next_state so they are flops yet track the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmr        <= '0;
      puf_trig   <= 1'b0;
      chal_ready <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      state      <= next_state;
      tmr        <= tmr_next;
      puf_trig   <= (next_state == LAUNCH);
      chal_ready <= (next_state == IDLE);
      out_valid  <= (next_state == DONE);
    end
  end

  // Challenge register, held from capture until the block is idle again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      puf_chal <= '0;
    end else if (accept) begin
      puf_chal <= chal_in;
    end
  end

  // Sticky per-bit instability from the core's stability flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad <= '0;
    end else if (accept) begin
      bad <= '0;
    end else if (sample) begin
      bad <= bad | ~samp_stab;
    end
  end

  // Result registers; loaded only on entry to DONE so no partial result
  // is ever visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_resp     <= '0;
      out_resp_xor <= 1'b0;
      out_unstable <= '0;
    end else if (finish) begin
      out_resp     <= res_resp;
      out_resp_xor <= ^res_resp;
      out_unstable <= res_unstable;
    end
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl
// Directed bench for puf_eval_ctrl. Expected results come from a small
// reference model of the voting rule, pushed to a queue at challenge capture
// and popped when out_valid rises. Expectations follow PUF_EVAL_VOTE_EN.
module tb_puf_eval_ctrl;

  localparam int TW = 4;
  localparam int ST = 64;
  localparam int NV = 7;
  localparam int S  = 8;
  localparam int R  = 4;
`ifdef PUF_EVAL_VOTE_EN
  localparam int NV_EFF = NV;
`else
  localparam int NV_EFF = 1;
`endif
  localparam int LAT = NV_EFF * (S + R) + 1;

  typedef struct {
    logic [ST-1:0] chal;
    logic [TW-1:0] resp;
    logic          xr;
    logic [TW-1:0] unst;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [ST-1:0] chal_in;
  logic          chal_valid;
  logic          chal_ready;
  logic [ST-1:0] puf_chal;
  logic          puf_trig;
  logic [TW-1:0] puf_resp;
  logic [TW-1:0] puf_stable_each;
  logic [TW-1:0] out_resp;
  logic          out_resp_xor;
  logic [TW-1:0] out_unstable;
  logic          out_valid;
  logic          out_ready;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [TW-1:0] rv [NV];
  logic [TW-1:0] sv [NV];

  puf_eval_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .chal_in         (chal_in),
    .chal_valid      (chal_valid),
    .chal_ready      (chal_ready),
    .puf_chal        (puf_chal),
    .puf_trig        (puf_trig),
    .puf_resp        (puf_resp),
    .puf_stable_each (puf_stable_each),
    .out_resp        (out_resp),
    .out_resp_xor    (out_resp_xor),
    .out_unstable    (out_unstable),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [ST-1:0] ch);
    exp_t e;
    int   n1;
    logic b;
    e.chal = ch;
    e.resp = '0;
    e.unst = '0;
    for (int i = 0; i < TW; i++) begin
      n1 = 0;
      b  = 1'b0;
      for (int k = 0; k < NV_EFF; k++) begin
        n1 += int'(rv[k][i]);
        if (!sv[k][i]) b = 1'b1;
      end
      e.resp[i] = (n1 > NV_EFF / 2);
      e.unst[i] = b || ((n1 != 0) && (n1 != NV_EFF));
    end
    e.xr = ^e.resp;
    return e;
  endfunction

  // Called #1 after an edge; returns #1 after the capturing edge.
  task automatic start(input logic [ST-1:0] ch, input bit push);
    int n = 0;
    chal_in    = ch;
    chal_valid = 1'b1;
    while (chal_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", chal_ready, 1'b1);
    @(posedge clk); #1;
    chal_valid = 1'b0;
    chal_in    = ~ch;
    if (push) q.push_back(model(ch));
  endtask

  // Runs one challenge from the cycle after capture to DONE and compares.
  task automatic eval_body(input logic [ST-1:0] ch);
    bit   chal_bad = 1'b0;
    bit   trig_bad = 1'b0;
    bit   early    = 1'b0;
    int   n        = 0;
    exp_t e;
    for (int c = 0; c < NV_EFF * (S + R); c++) begin
      if (c % (S + R) == 0) begin
        puf_resp        = rv[c / (S + R)];
        puf_stable_each = sv[c / (S + R)];
      end
      if (puf_chal !== ch) chal_bad = 1'b1;
      if (puf_trig !== ((c % (S + R)) < S)) trig_bad = 1'b1;
      if (out_valid !== 1'b0) early = 1'b1;
      @(posedge clk); #1;
    end
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("chal_held", chal_bad, 1'b0);
    check("trig_pattern", trig_bad, 1'b0);
    check("no_early_valid", early, 1'b0);
    check("latency", NV_EFF * (S + R) + 1 + n, LAT);
    check("done_chal_ready", chal_ready, 1'b0);
    check("sb_nonempty", q.size() > 0, 1'b1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("done_chal", puf_chal, e.chal);
      check("out_resp", out_resp, e.resp);
      check("out_resp_xor", out_resp_xor, e.xr);
      check("out_unstable", out_unstable, e.unst);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_valid", out_valid, 1'b0);
    check("idle_ready", chal_ready, 1'b1);
  endtask

  initial begin
    bit            bp_bad;
    bit            rst_bad;
    logic [TW-1:0] snap_resp;
    logic [TW-1:0] snap_unst;
    logic          snap_xr;

    rst_n           = 1'b0;
    chal_in         = '0;
    chal_valid      = 1'b0;
    puf_resp        = '0;
    puf_stable_each = '0;
    out_ready       = 1'b0;
    #12;
    check("rst_chal_ready", chal_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_puf_trig", puf_trig, 1'b0);
    check("rst_puf_chal", puf_chal, 64'h0);
    check("rst_out_resp", out_resp, 4'h0);
    check("rst_out_xor", out_resp_xor, 1'b0);
    check("rst_out_unst", out_unstable, 4'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the third trigger-high cycle aborts without any result.
    puf_resp        = 4'b1111;
    puf_stable_each = 4'b1111;
    start(64'h0123_4567_89AB_CDEF, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_trig_high", puf_trig, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_trig", puf_trig, 1'b0);
    check("mid_rst_ready", chal_ready, 1'b1);
    check("mid_rst_valid", out_valid, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    rst_bad = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || puf_trig !== 1'b0) rst_bad = 1'b1;
    end
    check("post_rst_quiet", rst_bad, 1'b0);
    for (int k = 0; k < NV; k++) begin
      rv[k] = 4'b1111;
      sv[k] = 4'b1111;
    end
    start(64'hFEED_FACE_CAFE_0001, 1'b1);
    eval_body(64'hFEED_FACE_CAFE_0001);
    release_out();

    // Clean evaluation.
    for (int k = 0; k < NV; k++) begin
      rv[k] = 4'b1010;
      sv[k] = 4'b1111;
    end
    start(64'hDEADBEEF_01234567, 1'b1);
    eval_body(64'hDEADBEEF_01234567);
    release_out();

    // Noisy bit 0: set in evaluations 0-3, clear in 4-6.
    for (int k = 0; k < NV; k++) begin
      rv[k] = (k < 4) ? 4'b0001 : 4'b0000;
      sv[k] = 4'b1111;
    end
    start(64'h1111_2222_3333_4444, 1'b1);
    eval_body(64'h1111_2222_3333_4444);
    release_out();

    // Stability flag for bit 3 drops during evaluation 5 only.
    for (int k = 0; k < NV; k++) begin
      rv[k] = 4'b1111;
      sv[k] = (k == 5) ? 4'b0111 : 4'b1111;
    end
    start(64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
    eval_body(64'hA5A5_5A5A_0F0F_F0F0);

    // Back-pressure in DONE with a second challenge already offered.
    snap_resp  = out_resp;
    snap_unst  = out_unstable;
    snap_xr    = out_resp_xor;
    chal_in    = 64'h5555_AAAA_1234_9876;
    chal_valid = 1'b1;
    bp_bad     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_resp !== snap_resp || out_unstable !== snap_unst ||
          out_resp_xor !== snap_xr || out_valid !== 1'b1 ||
          chal_ready !== 1'b0 || puf_trig !== 1'b0 ||
          puf_chal !== 64'hA5A5_5A5A_0F0F_F0F0) bp_bad = 1'b1;
    end
    check("bp_frozen", bp_bad, 1'b0);
    for (int k = 0; k < NV; k++) begin
      rv[k] = 4'b0110;
      sv[k] = 4'b1111;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ovl_ready_after_hs", chal_ready, 1'b1);
    check("ovl_not_launched", puf_trig, 1'b0);
    check("ovl_old_chal", puf_chal, 64'hA5A5_5A5A_0F0F_F0F0);
    @(posedge clk); #1;
    chal_valid = 1'b0;
    q.push_back(model(64'h5555_AAAA_1234_9876));
    check("ovl_launched", puf_trig, 1'b1);
    eval_body(64'h5555_AAAA_1234_9876);
    release_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
